// File: rtl/a2d_pot_seq_pkg.sv
// a2d_pot_seq_pkg: shared state type and SPI frame layout for the slide-pot A2D sequencer
package a2d_pot_seq_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;
    localparam int FRM_W = 16;
    localparam int RES_W = 12;
    localparam int ADDR_W = 3;
    localparam int ADDR_LSB = 11;
    function automatic logic [FRM_W-1:0] mk_frame(input logic [ADDR_W-1:0] addr);
        logic [FRM_W-1:0] f;
        f = '0;
        f[ADDR_LSB +: ADDR_W] = addr;
        return f;
    endfunction
endpackage

// File: rtl/a2d_pot_seq_spi_mstr16.sv
// spi_mstr16: one 16-bit SPI frame (setup, 16 SCLK periods, gap) with a full-duplex shift register
module spi_mstr16
    import a2d_pot_seq_pkg::*;
#(
    parameter int SCLK_DIV = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wrt,
    input  logic [FRM_W-1:0] cmd,
    input  logic             MISO,
    output logic             SS_n,
    output logic             SCLK,
    output logic             MOSI,
    output logic [RES_W-1:0] rd_data,
    output logic             done
);
    localparam int CW = $clog2(SCLK_DIV);
    localparam logic [CW-1:0] QTR_END = CW'(SCLK_DIV / 4 - 1);
    localparam logic [CW-1:0] HALF = CW'(SCLK_DIV / 2);
    localparam logic [CW-1:0] RISE = CW'(SCLK_DIV / 2 - 1);
    localparam logic [CW-1:0] PER_END = CW'(SCLK_DIV - 1);

    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [3:0] bitc;
    logic [FRM_W-1:0] shreg;
    logic mosi_r, qtr_end, per_end, rise, fall, load;

    assign qtr_end = cnt == QTR_END;
    assign per_end = cnt == PER_END;
    assign rise = state == SHIFT && cnt == RISE;
    // the first fall keeps the MSB, so only falls 2..16 advance MOSI
    assign fall = state == SHIFT && per_end && bitc != 4'hF;
    assign load = wrt && (state == IDLE || done);
    assign rd_data = shreg[RES_W-1:0];

    always_ff @(posedge clk)
        if (!rst_n) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = wrt ? SETUP : IDLE;
            SETUP:   nxt = qtr_end ? SHIFT : SETUP;
            SHIFT:   nxt = per_end && &bitc ? GAP : SHIFT;
            GAP:     nxt = qtr_end ? (wrt ? SETUP : IDLE) : GAP;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        SS_n = state == IDLE || state == GAP;
        SCLK = !(state == SHIFT && cnt < HALF);
        MOSI = !SS_n && mosi_r;
        done = state == GAP && qtr_end;
    end

    always_ff @(posedge clk)
        if (!rst_n) begin
            cnt <= '0;
            bitc <= '0;
            shreg <= '0;
            mosi_r <= 1'b0;
        end else begin
            cnt <= (state == IDLE || state != nxt || per_end) ? '0 : cnt + 1'b1;
            if (state == SHIFT && per_end) bitc <= bitc + 4'd1;
            if (load) shreg <= cmd;
            else if (rise) shreg <= {shreg[FRM_W-2:0], MISO};
            if (load) mosi_r <= cmd[FRM_W-1];
            else if (fall) mosi_r <= shreg[FRM_W-1];
        end
endmodule

// File: rtl/a2d_pot_seq.sv
// a2d_pot_seq: sweeps NUM_CH pot channels through a 16-bit SPI A2D, one trailing dummy frame
module a2d_pot_seq
    import a2d_pot_seq_pkg::*;
#(
    parameter int NUM_CH = 5,
    parameter int SCLK_DIV = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [23:0] POT,
    output logic [2:0]  pot_ch,
    output logic        pot_vld,
    output logic        busy,
    output logic        done
);
    localparam logic [2:0] LAST = 3'(NUM_CH);

    logic [2:0] k, k_nxt;
    logic wrt, frm_done;
    logic [FRM_W-1:0] cmd;
    logic [RES_W-1:0] rd;

    // cmd is loaded on the same edge k advances, so address from the upcoming index
    assign k_nxt = busy ? k + 3'd1 : 3'd0;
    assign cmd = mk_frame(k_nxt < LAST ? k_nxt : 3'd0);
    assign wrt = busy ? frm_done && k < LAST : strt;

    spi_mstr16 #(.SCLK_DIV(SCLK_DIV)) u_spi (
        .clk(clk),
        .rst_n(rst_n),
        .wrt(wrt),
        .cmd(cmd),
        .MISO(MISO),
        .SS_n(SS_n),
        .SCLK(SCLK),
        .MOSI(MOSI),
        .rd_data(rd),
        .done(frm_done)
    );

    always_ff @(posedge clk)
        if (!rst_n) begin
            k <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            pot_vld <= 1'b0;
            POT <= '0;
            pot_ch <= '0;
        end else begin
            busy <= busy ? !done : strt;
            pot_vld <= busy && frm_done && k != 3'd0;
            done <= busy && frm_done && k == LAST;
            if (busy && frm_done) begin
                k <= k < LAST ? k + 3'd1 : 3'd0;
                if (k != 3'd0) begin
                    POT <= {rd, RES_W'(0)};
                    pot_ch <= k - 3'd1;
                end
            end
        end
endmodule

// File: tb/tb_a2d_pot_seq.sv
// tb_a2d_pot_seq: A2D peripheral model plus table-driven, random and corner-case sweep checks
module tb_a2d_pot_seq;
    localparam int NUM_CH = 5;

    typedef struct packed {
        logic [1:0]       mode;
        logic [4:0][23:0] exp;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0, strt = 1'b0, MISO;
    logic SS_n, SCLK, MOSI, pot_vld, busy, done;
    logic [23:0] POT;
    logic [2:0] pot_ch;

    int n_chk = 0, n_fail = 0;
    int mode = 0, sweep_base = 0;
    logic [11:0] rnd_val [8];

    int nfr = 0, rises = 0, falls = 0, sclk_viol = 0, low_viol = 0, done_bad = 0;
    logic ss_q = 1'b1, sclk_q = 1'b1, done_q = 1'b0;
    logic [2:0] prev_addr = 3'd0;
    logic [15:0] miso_sr = 16'h0, mosi_cap = 16'h0;
    logic [2:0] fr_addr [$];
    int fr_falls [$];
    logic [26:0] vld_q [$];

    a2d_pot_seq #(.NUM_CH(NUM_CH), .SCLK_DIV(32)) dut (
        .clk(clk), .rst_n(rst_n), .strt(strt), .MISO(MISO), .SS_n(SS_n), .SCLK(SCLK),
        .MOSI(MOSI), .POT(POT), .pot_ch(pot_ch), .pot_vld(pot_vld), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    assign MISO = miso_sr[15];

    function automatic logic [11:0] a2d_val(input logic [2:0] ch, input int f);
        if (mode == 0) return 12'(32'(ch) * 257);
        if (mode == 1) return (f % 2 == 1) ? 12'hFFF : 12'h000;
        return rnd_val[ch];
    endfunction

    // A2D model: answers each frame with the previous frame's channel, shifting on SCLK falls
    always @(negedge clk) begin
        if (ss_q && !SS_n) begin
            miso_sr = {4'h0, a2d_val(prev_addr, nfr - sweep_base)};
            rises = 0;
            falls = 0;
            mosi_cap = 16'h0;
        end else if (!SS_n) begin
            if (!sclk_q && SCLK) begin
                mosi_cap = {mosi_cap[14:0], MOSI};
                rises++;
            end
            if (sclk_q && !SCLK) begin
                falls++;
                if (rises > 0) miso_sr = miso_sr << 1;
            end
        end
        if (!ss_q && SS_n) begin
            fr_addr.push_back(mosi_cap[13:11]);
            fr_falls.push_back(falls);
            prev_addr = mosi_cap[13:11];
            nfr++;
        end
        if (SS_n && !SCLK) sclk_viol++;
        if (POT[11:0] != 12'h0) low_viol++;
        if (pot_vld) vld_q.push_back({pot_ch, POT});
        if (done && (!pot_vld || pot_ch != 3'(NUM_CH - 1))) done_bad++;
        if (done_q && busy) done_bad++;
        done_q = done;
        ss_q = SS_n;
        sclk_q = SCLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic start_sweep(output int fb, output int vb);
        fb = fr_addr.size();
        vb = vld_q.size();
        sweep_base = nfr;
        strt = 1'b1;
        @(negedge clk);
        strt = 1'b0;
        check("busy_after_strt", 32'(busy), 1);
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (done !== 1'b1 && cyc < 8000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " done_seen"}, 32'(done), 1);
    endtask

    task automatic verify(input int fb, input int vb, input int nsw, input logic [4:0][23:0] exp,
                          input string tag);
        check({tag, " frames"}, fr_addr.size() - fb, 6 * nsw);
        check({tag, " vld_count"}, vld_q.size() - vb, 5 * nsw);
        for (int i = 0; i < 5 * nsw; i++)
            if (vb + i < vld_q.size()) begin
                check({tag, " pot_ch"}, 32'(vld_q[vb+i][26:24]), i % 5);
                check({tag, " POT"}, 32'(vld_q[vb+i][23:0]), 32'(exp[i%5]));
            end
        for (int f = 0; f < 6 * nsw; f++)
            if (fb + f < fr_addr.size()) begin
                check({tag, " mosi_addr"}, 32'(fr_addr[fb+f]), (f % 6 < 5) ? f % 6 : 0);
                check({tag, " sclk_falls"}, fr_falls[fb+f], 16);
            end
    endtask

    initial begin
        vec_t tbl [2];
        logic [4:0][23:0] ex;
        int fb, vb, cyc, nf0, vb0;
        tbl[0].mode = 2'd0;
        tbl[0].exp = {24'h404000, 24'h303000, 24'h202000, 24'h101000, 24'h000000};
        tbl[1].mode = 2'd1;
        tbl[1].exp = {24'hFFF000, 24'h000000, 24'hFFF000, 24'h000000, 24'hFFF000};

        repeat (3) @(negedge clk);
        check("rst SS_n", 32'(SS_n), 1);
        check("rst SCLK", 32'(SCLK), 1);
        check("rst MOSI", 32'(MOSI), 0);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst pot_vld", 32'(pot_vld), 0);
        check("rst POT", 32'(POT), 0);
        check("rst pot_ch", 32'(pot_ch), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int t = 0; t < 2; t++) begin
            mode = int'(tbl[t].mode);
            start_sweep(fb, vb);
            wait_done("table");
            repeat (4) @(negedge clk);
            verify(fb, vb, 1, tbl[t].exp, "table");
        end

        mode = 0;
        start_sweep(fb, vb);
        repeat (1500) @(negedge clk);
        strt = 1'b1;
        @(negedge clk);
        strt = 1'b0;
        wait_done("mid_strt");
        repeat (4) @(negedge clk);
        verify(fb, vb, 1, tbl[0].exp, "mid_strt");
        repeat (1200) @(negedge clk);
        check("mid_strt no_queue", fr_addr.size() - fb, 6);

        start_sweep(fb, vb);
        wait_done("back2back a");
        @(negedge clk);
        strt = 1'b1;
        @(negedge clk);
        strt = 1'b0;
        wait_done("back2back b");
        repeat (4) @(negedge clk);
        verify(fb, vb, 2, tbl[0].exp, "back2back");

        start_sweep(fb, vb);
        cyc = 0;
        while (!(nfr - sweep_base == 3 && !SS_n && rises == 8) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("reset reach_frame3_bit7", 32'(cyc < 5000), 1);
        check("reset vld_before", vld_q.size() - vb, 2);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset SS_n", 32'(SS_n), 1);
        check("reset SCLK", 32'(SCLK), 1);
        check("reset MOSI", 32'(MOSI), 0);
        check("reset busy", 32'(busy), 0);
        check("reset POT", 32'(POT), 0);
        check("reset pot_ch", 32'(pot_ch), 0);
        check("reset pot_vld", 32'(pot_vld), 0);
        rst_n = 1'b1;
        @(negedge clk);
        nf0 = nfr;
        vb0 = vld_q.size();
        repeat (1200) @(negedge clk);
        check("reset no_frames", nfr - nf0, 0);
        check("reset no_vld", vld_q.size() - vb0, 0);

        mode = 2;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 8; c++) rnd_val[c] = 12'($urandom_range(0, 4095));
            for (int j = 0; j < 5; j++) ex[j] = {rnd_val[j], 12'h000};
            start_sweep(fb, vb);
            wait_done("random");
            repeat (4) @(negedge clk);
            verify(fb, vb, 1, ex, "random");
        end

        check("sclk_high_when_ss_high", sclk_viol, 0);
        check("pot_low_bits_zero", low_viol, 0);
        check("done_timing", done_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
